// File: rtl/cpc_rom_loader_pkg.sv
// Shared types and helpers for the CPC ROM loader: FSM states, fixed ROM pages,
// and ASCII hex-digit decoding for expansion ROM file extensions.
package cpc_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WRITE
  } state_t;

  localparam logic [8:0] BASIC_PAGE  = 9'h100;
  localparam logic [8:0] AMSDOS_PAGE = 9'h107;

  // Returns {valid, value}; only '0'-'9' and upper-case 'A'-'F' count as hex.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46)
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'b0_0000;
  endfunction

endpackage

// File: rtl/cpc_rom_loader_ext_decode.sv
// Decodes the last two extension characters of an expansion ROM file into
// its target page and the combo (ROM + Multiface 2 tail) flag.
module cpc_ext_decode
  import cpc_loader_pkg::*;
#(
  parameter logic [8:0] BAD_PAGE = 9'h1EE
) (
  input  logic [15:0] ext,
  output logic [8:0]  page,
  output logic        combo
);

  logic [4:0] hi;
  logic [4:0] lo;

  always_comb begin
    hi    = hex_nibble(ext[15:8]);
    lo    = hex_nibble(ext[7:0]);
    page  = BAD_PAGE;
    combo = 1'b0;
    if (hi[4]) page[7:4] = hi[3:0];
    if (lo[4]) page[3:0] = lo[3:0];
    // Only a fully valid hex extension leaves the low (expansion) half of SDRAM.
    if (hi[4] && lo[4]) page[8] = 1'b0;
    if (ext == 16'h5A5A) begin
      page = '0;
    end else if (ext == 16'h5A30) begin
      page  = '0;
      combo = 1'b1;
    end
  end

endmodule

// File: rtl/cpc_rom_loader.sv
// Converts the hps_io byte download stream into ce_ref-paced SDRAM boot writes,
// mapping system and expansion ROM images onto 16 KB pages and tracking loaded pages.
module cpc_rom_loader #(
  parameter logic [8:0] MF2_PAGE = 9'h1FF,
  parameter logic [8:0] BAD_PAGE = 9'h1EE,
  parameter logic [8:0] OS_PAGE  = 9'h000
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         ce_ref,
  input  logic         ioctl_download,
  input  logic         ioctl_wr,
  input  logic [24:0]  ioctl_addr,
  input  logic [7:0]   ioctl_dout,
  input  logic [7:0]   ioctl_index,
  input  logic [31:0]  ioctl_file_ext,
  output logic         ioctl_wait,
  output logic         boot_wr,
  output logic [22:0]  boot_a,
  output logic [1:0]   boot_bank,
  output logic [7:0]   boot_dout,
  output logic [255:0] rom_map
);
  import cpc_loader_pkg::*;

  state_t      state;
  logic [8:0]  page;
  logic        combo;
  logic        old_download;
  logic [8:0]  dec_page;
  logic        dec_combo;
  logic [10:0] blk;
  logic        sys_drop;
  logic [8:0]  sys_page;
  logic [7:0]  exp_hi;
  logic [8:0]  wr_page;
  logic [1:0]  wr_bank;
  logic        dual;
  logic        is_system;
  logic        unused_ext;

  assign unused_ext = ^ioctl_file_ext[31:16];

  cpc_ext_decode #(
    .BAD_PAGE (BAD_PAGE)
  ) u_ext_decode (
    .ext   (ioctl_file_ext[15:0]),
    .page  (dec_page),
    .combo (dec_combo)
  );

  assign is_system = (ioctl_index == 8'd0);
  assign dual      = (ioctl_index[7:6] == 2'd1) | (|ioctl_index[5:0]);

  always_comb begin
    blk      = ioctl_addr[24:14];
    sys_drop = (blk > 11'd7);
    case (blk[1:0])
      2'd0:    sys_page = OS_PAGE;
      2'd1:    sys_page = BASIC_PAGE;
      2'd2:    sys_page = AMSDOS_PAGE;
      default: sys_page = MF2_PAGE;
    endcase
    // Expansion page offset wraps within 8 bits; page[8] never receives a carry.
    exp_hi = page[7:0] + ioctl_addr[21:14];
    if (is_system) begin
      wr_page = sys_page;
      wr_bank = {1'b0, blk[2]};
    end else begin
      wr_page = {page[8], exp_hi};
      wr_bank = {1'b0, &ioctl_index[7:6]};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state        <= IDLE;
      page         <= '0;
      combo        <= 1'b0;
      old_download <= 1'b0;
      ioctl_wait   <= 1'b0;
      boot_wr      <= 1'b0;
      boot_a       <= '0;
      boot_bank    <= '0;
      boot_dout    <= '0;
      rom_map      <= '0;
    end else begin
      old_download <= ioctl_download;
      if (ioctl_download && !old_download && !is_system) begin
        page  <= dec_page;
        combo <= dec_combo;
      end

      case (state)
        IDLE: begin
          if (ioctl_download && ioctl_wr && !(is_system && sys_drop)) begin
            boot_dout  <= ioctl_dout;
            boot_a     <= {wr_page, ioctl_addr[13:0]};
            boot_bank  <= wr_bank;
            ioctl_wait <= 1'b1;
            state      <= ARM;
          end
        end
        ARM: begin
          if (ce_ref) begin
            boot_wr <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (ce_ref) begin
            boot_wr <= 1'b0;
            if (dual && boot_bank == 2'd0) begin
              boot_bank <= 2'd1;
              state     <= ARM;
            end else begin
              ioctl_wait <= 1'b0;
              if (boot_a[22]) rom_map[boot_a[21:14]] <= 1'b1;
              // Combo image: the last byte of the first 16 KB redirects the rest to MF2.
              if (combo && boot_a[13:0] == 14'h3FFF) begin
                combo <= 1'b0;
                page  <= MF2_PAGE;
              end
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpc_rom_loader.sv
// Scoreboard bench for cpc_rom_loader: directed downloads push expected SDRAM writes,
// a monitor pops and compares each boot_wr pulse and its width.
module tb_cpc_rom_loader;

  logic         clk_sys = 1'b0;
  logic         reset_n;
  logic         ce_ref;
  logic         ioctl_download;
  logic         ioctl_wr;
  logic [24:0]  ioctl_addr;
  logic [7:0]   ioctl_dout;
  logic [7:0]   ioctl_index;
  logic [31:0]  ioctl_file_ext;
  logic         ioctl_wait;
  logic         boot_wr;
  logic [22:0]  boot_a;
  logic [1:0]   boot_bank;
  logic [7:0]   boot_dout;
  logic [255:0] rom_map;

  logic [3:0]   ce_cnt = 4'd0;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  bank;
    logic [7:0]  d;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] map_exp;
  int           checks = 0;
  int           errors = 0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) ce_cnt <= ce_cnt + 4'd1;
  assign ce_ref = (ce_cnt == 4'd15);

  cpc_rom_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ce_ref         (ce_ref),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_file_ext (ioctl_file_ext),
    .ioctl_wait     (ioctl_wait),
    .boot_wr        (boot_wr),
    .boot_a         (boot_a),
    .boot_bank      (boot_bank),
    .boot_dout      (boot_dout),
    .rom_map        (rom_map)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each rising boot_wr pops one expected write; each fall checks the 16-clk width.
  initial begin
    logic prev;
    int   hi;
    exp_t e;
    prev = 1'b0;
    hi   = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (boot_wr && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got a=%h bank=%h d=%h expected no write",
                   boot_a, boot_bank, boot_dout);
        end else begin
          e = exp_q.pop_front();
          check("boot_a", 256'(boot_a), 256'(e.a));
          check("boot_bank", 256'(boot_bank), 256'(e.bank));
          check("boot_dout", 256'(boot_dout), 256'(e.d));
        end
        hi = 1;
      end else if (boot_wr) begin
        hi++;
      end else if (prev && reset_n) begin
        check("boot_wr_width", 256'(hi), 256'd16);
      end
      prev = boot_wr;
    end
  end

  task automatic start_download(input logic [7:0] index, input logic [15:0] ext);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    ioctl_index    = index;
    ioctl_file_ext = {16'h0000, ext};
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_download();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input bit accept,
                           input logic [22:0] a, input logic [1:0] bank, input bit dual);
    int n;
    if (accept) begin
      exp_q.push_back('{a, bank, data});
      if (dual) exp_q.push_back('{a, 2'd1, data});
    end
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("wait_on_accept", 256'(ioctl_wait), 256'(accept));
    n = 0;
    while (ioctl_wait && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check("wait_released", 256'(ioctl_wait), 256'd0);
    if (!accept) repeat (40) @(negedge clk_sys);
  endtask

  initial begin
    int n;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    ioctl_file_ext = '0;
    map_exp        = '0;
    repeat (3) @(negedge clk_sys);
    check("reset_boot_wr", 256'(boot_wr), 256'd0);
    check("reset_wait", 256'(ioctl_wait), 256'd0);
    check("reset_boot_a", 256'(boot_a), 256'd0);
    check("reset_bank", 256'(boot_bank), 256'd0);
    check("reset_dout", 256'(boot_dout), 256'd0);
    check("reset_rom_map", rom_map, map_exp);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // System image: block 4 -> OS page, bank 1; block 8 dropped.
    start_download(8'h00, 16'h0000);
    send_byte(25'h0010005, 8'h3C, 1'b1, 23'h000005, 2'd1, 1'b0);
    check("map_sys_os", rom_map, map_exp);
    send_byte(25'h0020000, 8'h99, 1'b0, 23'h0, 2'd0, 1'b0);
    end_download();

    // Expansion "07" index 0x01: dual bank write to page 0x007.
    start_download(8'h01, 16'h3037);
    send_byte(25'h0000010, 8'hA5, 1'b1, 23'h01C010, 2'd0, 1'b1);
    check("map_exp07", rom_map, map_exp);
    end_download();

    // Malformed extension "GH", index 0xC1: bad page, bank 1 only.
    start_download(8'hC1, 16'h4748);
    send_byte(25'h0000123, 8'h5A, 1'b1, 23'h7B8123, 2'd1, 1'b0);
    map_exp[8'hEE] = 1'b1;
    check("map_bad_page", rom_map, map_exp);
    end_download();

    // Combo "Z0": page 0 until byte 3FFF, then MF2 page with wrapped offset.
    start_download(8'h80, 16'h5A30);
    send_byte(25'h0000000, 8'h11, 1'b1, 23'h000000, 2'd0, 1'b0);
    send_byte(25'h0003FFF, 8'h22, 1'b1, 23'h003FFF, 2'd0, 1'b0);
    check("map_combo_first", rom_map, map_exp);
    send_byte(25'h0004000, 8'h33, 1'b1, 23'h400000, 2'd0, 1'b0);
    map_exp[8'h00] = 1'b1;
    check("map_combo_wrap", rom_map, map_exp);
    end_download();

    // Reset during WRITE aborts the byte and clears rom_map.
    start_download(8'h00, 16'h0000);
    exp_q.push_back('{23'h000006, 2'd1, 8'h77});
    @(negedge clk_sys);
    ioctl_addr = 25'h0010006;
    ioctl_dout = 8'h77;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    n = 0;
    while (!boot_wr && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("abort_write_started", 256'(boot_wr), 256'd1);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    map_exp = '0;
    check("abort_boot_wr", 256'(boot_wr), 256'd0);
    check("abort_wait", 256'(ioctl_wait), 256'd0);
    check("abort_rom_map", rom_map, map_exp);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Clean restart: block 1 -> BASIC page, block 7 -> MF2 page.
    start_download(8'h00, 16'h0000);
    send_byte(25'h0004007, 8'hC3, 1'b1, 23'h400007, 2'd0, 1'b0);
    map_exp[8'h00] = 1'b1;
    check("map_basic", rom_map, map_exp);
    send_byte(25'h001C001, 8'hE8, 1'b1, 23'h7FC001, 2'd1, 1'b0);
    map_exp[8'hFF] = 1'b1;
    check("map_mf2", rom_map, map_exp);
    end_download();

    repeat (40) @(negedge clk_sys);
    check("queue_drained", 256'(exp_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
